param_reg_file: RTL and testbench
=================================

# param_reg_file

Parametrised multi-port register file for the MIPS pipeline decode stage, the successor to the fixed 32×32, two-read-port register file. It generalises data width, register count and read-port count. It adds three things the old block lacks: asynchronous reset of the whole array, optional write-to-read bypass in the same cycle, and a per-register pending scoreboard that lets hazard logic stall on in-flight producers such as loads.

## Interface
Parameters:
- DATA_W, 32, width of each register
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns the stored value
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never pending

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational from rd_addr; port k occupies bits [k*DATA_W +: DATA_W]
- rd_pending  out  NUM_RD  combinational; 1 = addressed register has an outstanding producer
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- issue_en  in  1  marks register issue_addr pending (producer issued)
- issue_addr  in  ADDR_W  index of the register to mark pending

## Operation
- Storage: depth × DATA_W register array plus a depth-bit pending vector.
- Reset (rst_n low): every register cleared to 0 and every pending bit cleared to 0, immediately and independent of clk. While reset is held, rd_data = 0 and rd_pending = 0 on all ports.
- Write: at the rising edge with wr_en=1, mem[wr_addr] ← wr_data and pending[wr_addr] ← 0.
- Issue: at the rising edge with issue_en=1, pending[issue_addr] ← 1.
- Issue and write to the same address in one cycle: issue wins, so pending ends at 1 (a newer producer exists) and the data is still written. Issue and write to different addresses are applied independently.
- Read, port k:
  - If BYPASS=1, wr_en=1, wr_addr==rd_addr_k, and (ZERO_REG=0 or address≠0): rd_data_k = wr_data and rd_pending_k = 0.
  - Otherwise rd_data_k = mem[rd_addr_k] and rd_pending_k = pending[rd_addr_k].
- Several ports may read the same address; each returns an identical result.
- ZERO_REG=1:
  - writes to address 0 are discarded;
  - issues to address 0 are discarded;
  - reads of address 0 return 0 with pending 0, and bypass is suppressed.
- No arithmetic. All index compares are full ADDR_W-bit equality, so there is no aliasing or wrap-around.

## Timing
- Read latency is 0 cycles (combinational). Write and issue latency is 1 cycle: the stored value and pending bit are visible from the edge that captures them.
- With BYPASS=0, a read of the address being written returns the old value in that cycle and the new value after the edge.
- Reset assertion mid-write: the write is lost and the array stays 0. The first write is accepted on the first rising edge after rst_n rises.
- No handshake and no backpressure: every strobe is accepted every cycle.

## Structure
- Shared package reg_file_pkg:
  - default DATA_W and ADDR_W;
  - ZERO_IDX constant = 0;
  - register-index typedef reg_idx_t.
- One sub-module, reg_file_rd_port: bypass/zero mux for a single port (inputs: stored data, pending bit, write strobe/address/data). It is generated NUM_RD times.
- Storage, pending vector and reset logic live in the top module.

## Test plan
- Reset: write 32'd55 to r1, assert rst_n=0 between edges → rd_data for r1 is 0 immediately and rd_pending=0; no write takes effect while reset is low.
- Basic write/read: write r1=55 then r2=0xDEADBEEF; next cycle port0=r1 and port1=r2 → 55 and 0xDEADBEEF; back-to-back writes to r31 (1, then 2) → reading r31 afterwards returns 2.
- Bypass: BYPASS=1, wr_en=1 with r3=7 while port0 reads r3 → rd_data=7 in the same cycle. With BYPASS=0 the same stimulus → the old value in that cycle, 7 after the edge.
- Zero register: write r0=0xFFFF_FFFF and issue r0 → reads of r0 return 0 with pending 0, including in the write cycle. With ZERO_REG=0 the value is stored.
- Scoreboard: issue r5 → rd_pending=1 from the next cycle; write r5=9 → pending clears after the edge (and immediately via bypass when BYPASS=1). Issue and write r5 together → pending=1 and value=9.
- Parameter sweep: NUM_RD=4, DATA_W=64, ADDR_W=4 → all four ports read distinct registers correctly, and a random write/issue sequence matches a reference model.

Source files
------------

// File: rtl/param_reg_file_pkg.sv
// Shared definitions for the parametrised register file: default geometry,
// the hardwired-zero register index and the register-index type.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Index of the register that reads as zero when ZERO_REG is enabled.
  localparam int ZERO_IDX = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/param_reg_file_rd_port.sv
// One read port: selects between the stored value, same-cycle write data
// (bypass) and the hardwired zero register.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_pending,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_pending
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic is_zero;
  logic fwd_hit;

  // Zero register beats bypass, bypass beats the stored value; a forwarded
  // write always reads as not pending because it retires the producer.
  always_comb begin
    is_zero    = (ZERO_REG != 0) && (rd_addr == ZERO_ADDR);
    fwd_hit    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    rd_data    = mem_data;
    rd_pending = mem_pending;
    if (is_zero) begin
      rd_data    = '0;
      rd_pending = 1'b0;
    end else if (fwd_hit) begin
      rd_data    = wr_data;
      rd_pending = 1'b0;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Parametrised multi-port register file with asynchronous reset, optional
// write-to-read bypass and a per-register pending scoreboard.
// There is no handshake: wr_en and issue_en are single-cycle strobes that are
// always accepted on the rising edge; reads are purely combinational.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic              issue_ok;
  logic              fwd_en;

  // Discard writes and issues aimed at the hardwired zero register.
  always_comb begin
    wr_ok    = wr_en;
    issue_ok = issue_en;
    if (ZERO_REG != 0) begin
      if (wr_addr == ZERO_ADDR) wr_ok = 1'b0;
      if (issue_addr == ZERO_ADDR) issue_ok = 1'b0;
    end
  end

  // Bypass is disabled while reset is held so every port reads zero.
  assign fwd_en = wr_en & rst_n;

  // Register array: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Pending scoreboard: a write retires the producer, an issue in the same
  // cycle is applied last so the newer producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (wr_ok) pending[wr_addr] <= 1'b0;
      if (issue_ok) pending[issue_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

    reg_file_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .rd_addr    (addr_k),
      .mem_data   (mem[addr_k]),
      .mem_pending(pending[addr_k]),
      .wr_en      (fwd_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_data    (rd_data[k*DATA_W +: DATA_W]),
      .rd_pending (rd_pending[k])
    );
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: three configurations (default, no-bypass/no-zero,
// 4-port 64-bit 16-entry) checked against an array model every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_param_reg_file;
  import reg_file_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus shared by configs A and B ----------------
  logic        wr_en      = 1'b0;
  reg_idx_t    wr_addr    = '0;
  logic [31:0] wr_data    = '0;
  logic        issue_en   = 1'b0;
  reg_idx_t    issue_addr = '0;
  reg_idx_t    rd_addr0   = '0;
  reg_idx_t    rd_addr1   = '0;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_pend_a, rd_pend_b;
  assign rd_addr = {rd_addr1, rd_addr0};

  // ---------------- stimulus for config C ----------------
  logic         c_wr_en      = 1'b0;
  logic [3:0]   c_wr_addr    = '0;
  logic [63:0]  c_wr_data    = '0;
  logic         c_issue_en   = 1'b0;
  logic [3:0]   c_issue_addr = '0;
  logic [3:0]   c_rd_a [4]   = '{default: '0};
  logic [15:0]  c_rd_addr;
  logic [255:0] c_rd_data;
  logic [3:0]   c_rd_pend;
  assign c_rd_addr = {c_rd_a[3], c_rd_a[2], c_rd_a[1], c_rd_a[0]};

  param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pending(rd_pend_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr));

  param_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pend_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr));

  param_reg_file #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_pending(c_rd_pend),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .issue_en(c_issue_en), .issue_addr(c_issue_addr));

  // ---------------- behavioural model ----------------
  // Index 0 = config A (bypass, zero reg), index 1 = config B (neither).
  logic [31:0] m_ab [2][32];
  bit          p_ab [2][32];
  logic [63:0] m_c  [16];
  bit          p_c  [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 32; r++) begin
          m_ab[i][r] = '0;
          p_ab[i][r] = 1'b0;
        end
      for (int r = 0; r < 16; r++) begin
        m_c[r] = '0;
        p_c[r] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en && !(i == 0 && wr_addr == 0)) begin
          m_ab[i][wr_addr] = wr_data;
          p_ab[i][wr_addr] = 1'b0;
        end
        if (issue_en && !(i == 0 && issue_addr == 0)) p_ab[i][issue_addr] = 1'b1;
      end
      if (c_wr_en && c_wr_addr != 0) begin
        m_c[c_wr_addr] = c_wr_data;
        p_c[c_wr_addr] = 1'b0;
      end
      if (c_issue_en && c_issue_addr != 0) p_c[c_issue_addr] = 1'b1;
    end
  end

  // Expected {pending, data} of a read in the current cycle.
  function automatic logic [32:0] exp_ab(input int i, input reg_idx_t a);
    if (!rst_n) return '0;
    if (i == 0 && a == 0) return '0;
    if (i == 0 && wr_en && wr_addr == a) return {1'b0, wr_data};
    return {p_ab[i][a], m_ab[i][a]};
  endfunction

  function automatic logic [64:0] exp_c(input logic [3:0] a);
    if (!rst_n) return '0;
    if (a == 0) return '0;
    if (c_wr_en && c_wr_addr == a) return {1'b0, c_wr_data};
    return {p_c[a], m_c[a]};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  logic [64:0] exp_q[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic lit_ab(input string name, input int i, input int k,
                        input logic [31:0] d, input bit p);
    logic [31:0] ad;
    logic        ap;
    if (i == 0) begin
      ad = rd_data_a[k*32 +: 32];
      ap = rd_pend_a[k];
    end else begin
      ad = rd_data_b[k*32 +: 32];
      ap = rd_pend_b[k];
    end
    check(name, {32'b0, ap, ad}, {32'b0, p, d});
  endtask

  task automatic lit_c(input string name, input int k, input logic [63:0] d, input bit p);
    check(name, {c_rd_pend[k], c_rd_data[k*64 +: 64]}, {p, d});
  endtask

  // Compare every port of every config against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++)
          exp_q.push_back(65'(exp_ab(i, (k == 0) ? rd_addr0 : rd_addr1)));
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_c(c_rd_a[k]));
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 2; k++)
          check($sformatf("cmp_%s_p%0d", (i == 0) ? "a" : "b", k),
                (i == 0) ? {32'b0, rd_pend_a[k], rd_data_a[k*32 +: 32]}
                         : {32'b0, rd_pend_b[k], rd_data_b[k*32 +: 32]},
                exp_q.pop_front());
      for (int k = 0; k < 4; k++)
        check($sformatf("cmp_c_p%0d", k), {c_rd_pend[k], c_rd_data[k*64 +: 64]},
              exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = reg_idx_t'(a);
    wr_data = d;
  endtask

  function automatic logic [63:0] c_pat(input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | 64'(i);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    rd_addr0 = 5'd1;
    rd_addr1 = 5'd2;
    set_wr(1, 32'd55);
    #3;
    lit_ab("rst_bypass_gated", 0, 0, 32'd0, 1'b0);
    lit_ab("rst_b_zero", 1, 0, 32'd0, 1'b0);
    tick();
    wr_en = 1'b0;
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    look();
    lit_ab("no_write_in_reset", 1, 0, 32'd0, 1'b0);

    // basic write / read
    tick(); set_wr(1, 32'd55);
    tick(); set_wr(2, 32'hDEADBEEF);
    tick(); wr_en = 1'b0; rd_addr0 = 5'd1; rd_addr1 = 5'd2;
    look();
    lit_ab("basic_r1", 0, 0, 32'd55, 1'b0);
    lit_ab("basic_r2", 0, 1, 32'hDEADBEEF, 1'b0);
    lit_ab("basic_b_r1", 1, 0, 32'd55, 1'b0);

    // back-to-back writes to r31
    tick(); set_wr(31, 32'd1);
    tick(); set_wr(31, 32'd2);
    tick(); wr_en = 1'b0; rd_addr0 = 5'd31;
    look();
    lit_ab("r31_last_write", 0, 0, 32'd2, 1'b0);

    // bypass vs stored value
    tick(); set_wr(3, 32'd7); rd_addr0 = 5'd3;
    look();
    lit_ab("bypass_a", 0, 0, 32'd7, 1'b0);
    lit_ab("nobypass_b_old", 1, 0, 32'd0, 1'b0);
    tick(); wr_en = 1'b0;
    look();
    lit_ab("nobypass_b_new", 1, 0, 32'd7, 1'b0);

    // zero register
    tick(); set_wr(0, 32'hFFFF_FFFF); issue_en = 1'b1; issue_addr = 5'd0; rd_addr0 = 5'd0;
    look();
    lit_ab("zero_wr_cycle", 0, 0, 32'd0, 1'b0);
    tick(); wr_en = 1'b0; issue_en = 1'b0;
    look();
    lit_ab("zero_after", 0, 0, 32'd0, 1'b0);
    lit_ab("nozero_b_stored", 1, 0, 32'hFFFF_FFFF, 1'b1);

    // pending scoreboard
    tick(); issue_en = 1'b1; issue_addr = 5'd5; rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    look();
    lit_ab("issue_not_yet", 0, 0, 32'd0, 1'b0);
    tick(); issue_en = 1'b0;
    look();
    lit_ab("issue_pend_p0", 0, 0, 32'd0, 1'b1);
    lit_ab("issue_pend_p1", 0, 1, 32'd0, 1'b1);
    tick(); set_wr(5, 32'd9);
    look();
    lit_ab("retire_bypass_a", 0, 0, 32'd9, 1'b0);
    lit_ab("retire_wait_b", 1, 0, 32'd0, 1'b1);
    tick(); wr_en = 1'b0;
    look();
    lit_ab("retired_b", 1, 0, 32'd9, 1'b0);
    tick(); set_wr(5, 32'd9); issue_en = 1'b1; issue_addr = 5'd5;
    tick(); wr_en = 1'b0; issue_en = 1'b0;
    look();
    lit_ab("issue_wins_a", 0, 0, 32'd9, 1'b1);
    lit_ab("issue_wins_b", 1, 0, 32'd9, 1'b1);

    // reset mid-write
    tick(); set_wr(1, 32'd77); rd_addr0 = 5'd1;
    #2 rst_n = 1'b0;
    #1;
    lit_ab("rst_mid_a", 0, 0, 32'd0, 1'b0);
    lit_ab("rst_mid_b", 1, 0, 32'd0, 1'b0);
    tick();
    look();
    lit_ab("rst_held_b", 1, 0, 32'd0, 1'b0);
    #1 rst_n = 1'b1;
    tick(); wr_en = 1'b0;
    look();
    lit_ab("first_write_after_rst", 1, 0, 32'd77, 1'b0);

    // four-port wide config
    for (int i = 4; i < 8; i++) begin
      tick();
      c_wr_en = 1'b1; c_wr_addr = 4'(i); c_wr_data = c_pat(i);
    end
    tick(); c_wr_en = 1'b0; c_issue_en = 1'b1; c_issue_addr = 4'd9;
    tick(); c_issue_en = 1'b0;
    for (int k = 0; k < 4; k++) c_rd_a[k] = 4'(k + 4);
    look();
    for (int k = 0; k < 4; k++) lit_c($sformatf("c_port%0d", k), k, c_pat(k + 4), 1'b0);
    c_rd_a[2] = 4'd9;
    #1;
    lit_c("c_pend_r9", 2, 64'd0, 1'b1);

    // randomized traffic on all configs
    for (int n = 0; n < 400; n++) begin
      tick();
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = reg_idx_t'($urandom_range(0, 7));
      wr_data    = $urandom;
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = reg_idx_t'($urandom_range(0, 7));
      rd_addr0   = ($urandom_range(0, 1) != 0) ? wr_addr : reg_idx_t'($urandom_range(0, 31));
      rd_addr1   = ($urandom_range(0, 1) != 0) ? issue_addr : reg_idx_t'($urandom_range(0, 7));
      c_wr_en      = 1'($urandom_range(0, 1));
      c_wr_addr    = 4'($urandom_range(0, 15));
      c_wr_data    = {$urandom, $urandom};
      c_issue_en   = 1'($urandom_range(0, 1));
      c_issue_addr = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++)
        c_rd_a[k] = ($urandom_range(0, 2) == 0) ? c_wr_addr : 4'($urandom_range(0, 15));
      if (n == 200) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    tick();
    wr_en = 1'b0; issue_en = 1'b0; c_wr_en = 1'b0; c_issue_en = 1'b0;
    look();
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
